// File: rtl/mem_responder_if.sv
// Request/response channel between a load/store unit and a memory endpoint.
// The requester drives the request fields and rsp_ready; the memory side drives everything else.
`timescale 1ns/1ps

interface mem_responder_if #(
  parameter int DW = 64
);
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_addr;
  logic          req_wen;
  logic [3:0]    req_wlen;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wlen, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wlen, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding data-memory responder: word-organised SRAM with byte-lane stores
// and a fixed, programmable response latency.
`timescale 1ns/1ps

module mem_responder #(
  parameter int              DW    = 64,
  parameter int              DEPTH = 4096,
  parameter logic [DW-1:0]   BASE  = 64'h8000_0000,
  parameter int              LAT   = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_responder_if.slave bus
);

  localparam int         IW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [DW-1:0] mem [DEPTH];

  logic [DW-1:0] off;
  logic [2:0]    lane;
  logic [IW-1:0] idx;
  logic          in_range;
  logic          wlen_ok;
  logic [7:0]    base_mask;
  logic [2:0]    align_mask;
  logic [7:0]    wmask;
  logic [DW-1:0] wdata_sh;
  logic          req_err;
  logic          accept;
  logic          mem_we;

  // Request decode: offset into the array, lane, legality and the store byte mask.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    base_mask  = 8'h00;
    align_mask = 3'b000;
    wlen_ok    = 1'b1;
    case (bus.req_wlen)
      4'd1:    begin base_mask = 8'h01; align_mask = 3'b000; end
      4'd2:    begin base_mask = 8'h03; align_mask = 3'b001; end
      4'd4:    begin base_mask = 8'h0F; align_mask = 3'b011; end
      4'd8:    begin base_mask = 8'hFF; align_mask = 3'b111; end
      default: wlen_ok = 1'b0;
    endcase
    off      = bus.req_addr - BASE;
    lane     = off[2:0];
    idx      = off[IW+2:3];
    in_range = (off[DW-1:IW+3] == '0);
    req_err  = !in_range || !wlen_ok || ((lane & align_mask) != 3'b000);
    wmask    = base_mask << lane;
    wdata_sh = bus.req_wdata << {lane, 3'b000};
    accept   = bus.req_valid && (state_q == IDLE);
    mem_we   = accept && bus.req_wen && !req_err && !rst;
  end

  // NOTE: the array is deliberately left out of reset; only the control path is initialised.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (wmask[b]) mem[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = LAT_M1;
          err_d   = req_err;
          rdata_d = (req_err || bus.req_wen) ? '0 : mem[idx];
          state_d = (LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LAT=2 instance for functional scenarios and
// LAT=1 / LAT=15 instances for the latency sweep against a word model.
`timescale 1ns/1ps

module tb_mem_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          NDUT  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        req_valid [NDUT];
  logic [63:0] req_addr  [NDUT];
  logic        req_wen   [NDUT];
  logic [3:0]  req_wlen  [NDUT];
  logic [63:0] req_wdata [NDUT];
  logic        rsp_ready [NDUT];
  wire         req_ready_w [NDUT];
  wire         rsp_valid_w [NDUT];
  wire  [63:0] rsp_rdata_w [NDUT];
  wire         rsp_err_w   [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    mem_responder_if #(.DW(64)) bus ();
    assign bus.req_valid = req_valid[g];
    assign bus.req_addr  = req_addr[g];
    assign bus.req_wen   = req_wen[g];
    assign bus.req_wlen  = req_wlen[g];
    assign bus.req_wdata = req_wdata[g];
    assign bus.rsp_ready = rsp_ready[g];
    assign req_ready_w[g] = bus.req_ready;
    assign rsp_valid_w[g] = bus.rsp_valid;
    assign rsp_rdata_w[g] = bus.rsp_rdata;
    assign rsp_err_w[g]   = bus.rsp_err;
    mem_responder #(.DW(64), .DEPTH(DEPTH), .BASE(BASE), .LAT(L)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  // One complete transaction with rsp_ready held high; lat counts cycles from acceptance to rsp_valid.
  task automatic do_txn(input int d, input logic wen, input logic [63:0] addr, input logic [3:0] wlen,
                        input logic [63:0] wdata, output logic [63:0] rdata, output logic err,
                        output int lat, output int t_acc);
    int n;
    lat = -1; rdata = '0; err = 1'b0; t_acc = -1;
    @(negedge clk);
    req_valid[d] = 1'b1; req_wen[d] = wen; req_addr[d] = addr;
    req_wlen[d]  = wlen; req_wdata[d] = wdata; rsp_ready[d] = 1'b1;
    n = 0;
    while (req_ready_w[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (req_ready_w[d] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL txn_accept dut=%0d: req_ready=%b, required 1", d, req_ready_w[d]);
      req_valid[d] = 1'b0;
      return;
    end
    t_acc = cyc;
    @(negedge clk);
    req_valid[d] = 1'b0;
    n = 1;
    while (rsp_valid_w[d] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (rsp_valid_w[d] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL txn_response dut=%0d: no rsp_valid within %0d cycles", d, n);
      return;
    end
    lat = n; rdata = rsp_rdata_w[d]; err = rsp_err_w[d];
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (req_ready_w[d] !== 1'b1 || rsp_valid_w[d] !== 1'b0 || rsp_rdata_w[d] !== 64'h0 || rsp_err_w[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut=%0d: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
                 d, req_ready_w[d], rsp_valid_w[d], rsp_rdata_w[d], rsp_err_w[d]);
      end
    end
  endtask

  task automatic test_store_load();
    logic [63:0] rd; logic er; int lat, ta;
    do_txn(0, 1'b1, BASE + 64'd8, 4'd8, 64'h1122_3344_5566_7788, rd, er, lat, ta);
    checks++;
    if (er !== 1'b0 || rd !== 64'h0 || lat != 2) begin
      errors++;
      $display("FAIL store_rsp: err=%b rdata=%h lat=%0d, required 0 0 2", er, rd, lat);
    end
    do_txn(0, 1'b0, BASE + 64'd8, 4'd8, 64'h0, rd, er, lat, ta);
    checks++;
    if (er !== 1'b0 || rd !== 64'h1122_3344_5566_7788 || lat != 2) begin
      errors++;
      $display("FAIL load_rsp: err=%b rdata=%h lat=%0d, required 0 1122334455667788 2", er, rd, lat);
    end
  endtask

  task automatic test_byte_merge();
    logic [63:0] rd; logic er; int lat, ta;
    do_txn(0, 1'b1, BASE + 64'h0B, 4'd1, 64'hAA, rd, er, lat, ta);
    do_txn(0, 1'b1, BASE + 64'h0C, 4'd2, 64'hBEEF, rd, er, lat, ta);
    do_txn(0, 1'b0, BASE + 64'h08, 4'd8, 64'h0, rd, er, lat, ta);
    checks++;
    if (er !== 1'b0 || rd !== 64'h1122_BEEF_AA66_7788) begin
      errors++;
      $display("FAIL byte_merge: err=%b rdata=%h, required 0 1122beefaa667788", er, rd);
    end
  endtask

  task automatic test_errors();
    logic [63:0] rd; logic er; int lat, ta;
    logic        e_wen  [6];
    logic [63:0] e_addr [6];
    logic [3:0]  e_wlen [6];
    e_wen  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    e_addr = '{BASE + 64'd2, BASE, BASE + 64'(8 * DEPTH), BASE, BASE - 64'd8, BASE + 64'(8 * DEPTH)};
    e_wlen = '{4'd4, 4'd3, 4'd8, 4'd3, 4'd8, 4'd8};
    do_txn(0, 1'b1, BASE, 4'd8, 64'h0123_4567_89AB_CDEF, rd, er, lat, ta);
    for (int i = 0; i < 6; i++) begin
      do_txn(0, e_wen[i], e_addr[i], e_wlen[i], 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat, ta);
      checks++;
      if (er !== 1'b1 || rd !== 64'h0 || lat != 2) begin
        errors++;
        $display("FAIL error_rsp[%0d]: err=%b rdata=%h lat=%0d, required 1 0 2", i, er, rd, lat);
      end
      do_txn(0, 1'b0, BASE, 4'd8, 64'h0, rd, er, lat, ta);
      checks++;
      if (er !== 1'b0 || rd !== 64'h0123_4567_89AB_CDEF) begin
        errors++;
        $display("FAIL error_untouched[%0d]: err=%b rdata=%h, required 0 0123456789abcdef", i, er, rd);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = BASE + 64'd8;
    req_wlen[0] = 4'd8; rsp_ready[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 1;
    while (rsp_valid_w[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid_w[0] !== 1'b1 || rsp_rdata_w[0] !== 64'h1122_BEEF_AA66_7788 || req_ready_w[0] !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%b rdata=%h req_ready=%b, required 1 1122beefaa667788 0",
                 i, rsp_valid_w[0], rsp_rdata_w[0], req_ready_w[0]);
      end
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    checks++;
    if (rsp_valid_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b, required 1", rsp_valid_w[0]);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid_w[0] !== 1'b0 || req_ready_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_done: valid=%b req_ready=%b, required 0 1", rsp_valid_w[0], req_ready_w[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd; logic er; int lat, ta0, ta1;
    do_txn(0, 1'b0, BASE + 64'd8, 4'd8, 64'h0, rd, er, lat, ta0);
    do_txn(0, 1'b0, BASE + 64'd8, 4'd8, 64'h0, rd, er, lat, ta1);
    checks++;
    if (ta1 - ta0 != 3) begin
      errors++;
      $display("FAIL back_to_back: acceptance spacing=%0d, required 3", ta1 - ta0);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic er; int lat, ta;
    logic seen;
    @(negedge clk);
    req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = BASE + 64'd16;
    req_wlen[0] = 4'd8; req_wdata[0] = 64'hDEAD; rsp_ready[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    seen = rsp_valid_w[0];
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid_w[0] !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_valid: rsp_valid seen=%b, required 0", seen);
    end
    do_txn(0, 1'b0, BASE + 64'd16, 4'd8, 64'h0, rd, er, lat, ta);
    checks++;
    if (er !== 1'b0 || rd !== 64'hDEAD) begin
      errors++;
      $display("FAIL reset_mid_commit: err=%b rdata=%h, required 0 000000000000dead", er, rd);
    end
    // A request presented in the same cycle as reset must not be accepted.
    do_txn(0, 1'b1, BASE + 64'd24, 4'd8, 64'h5555, rd, er, lat, ta);
    @(negedge clk);
    req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = BASE + 64'd24;
    req_wlen[0] = 4'd8; req_wdata[0] = 64'h9999; rst = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0; rst = 1'b0;
    checks++;
    if (rsp_valid_w[0] !== 1'b0 || req_ready_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_priority_state: valid=%b req_ready=%b, required 0 1", rsp_valid_w[0], req_ready_w[0]);
    end
    do_txn(0, 1'b0, BASE + 64'd24, 4'd8, 64'h0, rd, er, lat, ta);
    checks++;
    if (rd !== 64'h5555) begin
      errors++;
      $display("FAIL reset_priority_data: rdata=%h, required 0000000000005555", rd);
    end
  endtask

  task automatic test_latency_sweep(input int d, input int lat_exp);
    logic [63:0] mdl [16];
    logic [63:0] rd, v;
    logic er;
    int lat, ta, idx, lane;
    logic [3:0] wl;
    for (int i = 0; i < 16; i++) begin
      v = {$urandom, $urandom};
      do_txn(d, 1'b1, BASE + 64'(8 * i), 4'd8, v, rd, er, lat, ta);
      mdl[i] = v;
      checks++;
      if (er !== 1'b0 || lat != lat_exp) begin
        errors++;
        $display("FAIL sweep_init dut=%0d word=%0d: err=%b lat=%0d, required 0 %0d", d, i, er, lat, lat_exp);
      end
    end
    for (int p = 0; p < 100; p++) begin
      idx = int'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: wl = 4'd1;
        1: wl = 4'd2;
        2: wl = 4'd4;
        default: wl = 4'd8;
      endcase
      lane = int'(wl) * int'($urandom_range(0, 8 / int'(wl) - 1));
      v = {$urandom, $urandom};
      do_txn(d, 1'b1, BASE + 64'(8 * idx + lane), wl, v, rd, er, lat, ta);
      for (int k = 0; k < int'(wl); k++) mdl[idx][(lane + k) * 8 +: 8] = v[k * 8 +: 8];
      checks++;
      if (er !== 1'b0 || rd !== 64'h0 || lat != lat_exp) begin
        errors++;
        $display("FAIL sweep_store dut=%0d pair=%0d: err=%b rdata=%h lat=%0d, required 0 0 %0d",
                 d, p, er, rd, lat, lat_exp);
      end
      do_txn(d, 1'b0, BASE + 64'(8 * idx + lane), wl, 64'h0, rd, er, lat, ta);
      checks++;
      if (er !== 1'b0 || rd !== mdl[idx] || lat != lat_exp) begin
        errors++;
        $display("FAIL sweep_load dut=%0d pair=%0d: err=%b rdata=%h lat=%0d, required 0 %h %0d",
                 d, p, er, rd, lat, mdl[idx], lat_exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      req_valid[d] = 1'b0; req_addr[d] = '0; req_wen[d] = 1'b0;
      req_wlen[d]  = 4'd8; req_wdata[d] = '0; rsp_ready[d] = 1'b1;
    end
    test_reset();
    test_store_load();
    test_byte_merge();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_latency_sweep(1, 1);
    test_latency_sweep(2, 15);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's data-memory request interface. It accepts one byte-addressed load or store at a time through a valid/ready request channel and holds a DW-wide word-organised SRAM array. After a programmable latency it returns the response, including read data, through a valid/ready response channel. It stands in for the DPI-backed memory as a synthesizable end point, and is used for multi-cycle memory bring-up of the core's load/store path.

## Interface
- `DW`, 64: data word width in bits; fixed at 64, so there are 8 byte lanes.
- `DEPTH`, 4096: number of DW-bit words in the array; power of two.
- `BASE`, 64'h8000_0000: byte address of word 0.
- `LAT`, 2: cycles from request acceptance to `rsp_valid`; legal range 1..15.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the responder can accept a request.
- `req_addr` in DW: byte address.
- `req_wen` in 1: 1 selects a store, 0 selects a load.
- `req_wlen` in 4: access size in bytes; legal values are 1, 2, 4 and 8.
- `req_wdata` in DW: store data, right-aligned (the least-significant `req_wlen` bytes are used).
- `rsp_valid` out 1: a response is present.
- `rsp_ready` in 1: the requester accepts the response.
- `rsp_rdata` out DW: the full aligned word for a load; 0 for a store or an error.
- `rsp_err` out 1: the request was rejected.

## Operation
- State machine states: IDLE, WAIT, RESP.
- `req_ready` = (state == IDLE). At most one request is outstanding.
- Acceptance happens on a rising edge with `req_valid && req_ready`. On that edge the block:
  - captures the request;
  - computes `off = req_addr - BASE` (modulo 2^DW), `idx = off >> 3` and `lane = off[2:0]`;
  - loads the latency counter with `LAT-1`;
  - moves to WAIT, or directly to RESP when LAT == 1.
- Error conditions, any of which sets `rsp_err`:
  - `idx >= DEPTH`;
  - `req_wlen` not in {1, 2, 4, 8};
  - `lane % req_wlen != 0` (misaligned).
- On error: the array is not touched and `rsp_rdata` = 0.
- Store:
  - Takes effect at the acceptance edge.
  - Byte mask = ((1 << req_wlen) - 1) << lane.
  - Array byte `lane+k` receives `req_wdata` byte k, for k < `req_wlen`.
  - Unmasked bytes are preserved.
- Load: samples `mem[idx]` at the acceptance edge into the response register. No extraction or sign-extension is done here; the requester's memory unit does it.
- WAIT: the counter decrements every cycle. When it reaches 0 the block moves to RESP on the next edge.
- RESP:
  - `rsp_valid` = 1.
  - `rsp_rdata` and `rsp_err` stay stable until the handshake.
  - On `rsp_valid && rsp_ready`, the block returns to IDLE.
  - A new request is accepted no earlier than the edge after that return (no same-cycle turnaround).
- Ordering: strictly in order. A load issued after a store to the same bytes returns the stored data.

## Timing
- Reset values:
  - state = IDLE;
  - `req_ready` = 1 in the first cycle after reset;
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0;
  - counter = 0;
  - array contents are not reset.
- Latency: for a request accepted at edge N, `rsp_valid` rises after edge N+LAT-1 and is visible in cycle N+LAT. With LAT == 1, the response is visible the cycle after acceptance.
- With `rsp_ready` held high, throughput is one request per LAT+1 cycles.
- Backpressure: `rsp_valid` and the response payload stay held for any number of `rsp_ready`-low cycles.
- Reset mid-operation:
  - A pending response is discarded and state returns to IDLE.
  - A store already accepted stays committed.
  - `rst` has priority over every handshake occurring in the same cycle.
- `req_*` inputs are ignored whenever `req_ready` = 0.
- All outputs are registered or decoded from state only; there is no combinational path from `req_*` or `rsp_ready` to any output.

## Test plan
- Reset, then store: `req_ready` is 1. Store `addr=BASE+8, wlen=8, wdata=64'h1122_3344_5566_7788`, then load `BASE+8` → load `rsp_rdata = 64'h1122_3344_5566_7788`, `rsp_err = 0`, `rsp_valid` exactly LAT cycles after each acceptance.
- Byte-lane merge: after the previous test, store `addr=BASE+0xB, wlen=1, wdata=8'hAA`, then store `addr=BASE+0xC, wlen=2, wdata=16'hBEEF` → a load of `BASE+8` returns `64'h1122_BEEF_AA66_7788`.
- Errors, one request each:
  - store `addr=BASE+2, wlen=4` (misaligned);
  - load with `wlen=3`;
  - load `BASE + 8*DEPTH` (out of range);
  - required response for each: `rsp_err = 1`, `rsp_rdata = 0`, a following load of `BASE+0` shows unchanged contents.
- Backpressure: load with `rsp_ready` low for 5 cycles → `rsp_valid` and `rsp_rdata` hold steady, `req_ready` = 0 throughout, a single handshake on the first `rsp_ready`-high cycle, `req_ready` = 1 in the next cycle.
- Reset mid-operation: accept a store `BASE+16 = 64'hDEAD`, then assert `rst` during WAIT → no `rsp_valid` is ever produced for it, and a subsequent load of `BASE+16` returns `64'hDEAD`.
- Latency sweep: instances with LAT=1 and LAT=15 run 100 random aligned load/store pairs against a byte-array model → all data matches and every response latency equals LAT.
